// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: a byte FIFO that feeds a UART transmitter through a
// start/done handshake.
//   - Circular FIFO of 2**ADDR_W bytes. A write to a full FIFO is dropped
//     and Ovf pulses for one cycle.
//   - FSM IDLE -> PULSE -> WAIT_DONE -> GAP. TxEn is held high for 2 cycles
//     so the transmitter's 2-stage edge detector sees a single rising edge.
//   - TxDone comes from the transmitter's tick domain. It is synchronised
//     through two flops before any use.
// Optional feature: define UART_TXF_TIMEOUT_EN to add a WAIT_DONE watchdog.
//   The watchdog lasts TIMEOUT_CYC cycles and sets a sticky Err flag.
//   When the macro is undefined there is no watchdog counter and Err is 0.
module uart_tx_feeder #(
  parameter int ADDR_W      = 4,
  parameter int TIMEOUT_CYC = 1048576
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              WrEn,
  input  logic [7:0]        WrData,
  input  logic              TxDone,
  output logic              TxEn,
  output logic [7:0]        TxData,
  output logic              Full,
  output logic              Empty,
  output logic [ADDR_W:0]   Level,
  output logic              Busy,
  output logic              Ovf,
  output logic              Err
);

  localparam int              DEPTH    = 2**ADDR_W;
  localparam logic [ADDR_W:0] LVL_FULL = (ADDR_W+1)'(DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PULSE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_GAP   = 2'd3;

  logic [7:0]        mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]   level_q;
  logic [1:0]        state_q, state_d;
  logic              pcnt_q, pcnt_d;
  logic [7:0]        txdata_q;
  logic              txen_q;
  logic              ovf_q;
  logic              sync1_q, done_s_q, done_prev_q;

  logic full, empty, push, pop, done_rise, timeout_hit;

  // Full is taken from the registered level, so a pop in the same cycle
  // cannot make room for a write that arrives while the FIFO is full.
  assign full      = (level_q == LVL_FULL);
  assign empty     = (level_q == '0);
  assign push      = WrEn & ~full;
  assign pop       = (state_q == S_IDLE) & ~empty;
  assign done_rise = done_s_q & ~done_prev_q;

  // FIFO storage. It is not reset because the pointers and level define
  // which entries are valid.
  always_ff @(posedge Clk) begin
    if (push) mem_q[wr_ptr_q] <= WrData;
  end

  // Pointers and occupancy. The pointers wrap naturally at 2**ADDR_W.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // Overflow pulse: one cycle for each write that is rejected.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) ovf_q <= 1'b0;
    else        ovf_q <= WrEn & full;
  end

  // Two-flop synchroniser for TxDone. A delayed copy is kept for edge detection.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      sync1_q     <= 1'b0;
      done_s_q    <= 1'b0;
      done_prev_q <= 1'b0;
    end else begin
      sync1_q     <= TxDone;
      done_s_q    <= sync1_q;
      done_prev_q <= done_s_q;
    end
  end

`ifdef UART_TXF_TIMEOUT_EN
  localparam int              TO_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  logic [TO_W-1:0] to_cnt_q;
  logic            err_q;

  assign timeout_hit = (state_q == S_WAIT) && (to_cnt_q == TO_LAST);

  // Watchdog: cleared on entry to WAIT_DONE and counting each cycle spent
  // in it. Err is sticky until reset. A done edge that arrives in the same
  // cycle as the limit takes priority.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      to_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state_q == S_PULSE && state_d == S_WAIT) to_cnt_q <= '0;
      else if (state_q == S_WAIT)                  to_cnt_q <= to_cnt_q + 1'b1;
      if (timeout_hit && !done_rise) err_q <= 1'b1;
    end
  end

  assign Err = err_q;
`else
  assign timeout_hit = 1'b0;
  assign Err         = 1'b0;
`endif

  // Next-state logic for the handshake FSM.
  always_comb begin
    state_d = state_q;
    pcnt_d  = pcnt_q;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          state_d = S_PULSE;
          pcnt_d  = 1'b0;
        end
      end
      S_PULSE: begin
        if (pcnt_q) state_d = S_WAIT;
        else        pcnt_d  = 1'b1;
      end
      S_WAIT: begin
        if (done_rise || timeout_hit) state_d = S_GAP;
      end
      S_GAP: begin
        // Hold here until done has dropped, so the next start cannot be
        // issued while the transmitter is still signalling done.
        if (!done_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM registers. TxEn is registered from the next state, so it is high
  // for exactly the two cycles spent in PULSE and has no glitches.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= S_IDLE;
      pcnt_q  <= 1'b0;
      txen_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pcnt_q  <= pcnt_d;
      txen_q  <= (state_d == S_PULSE);
    end
  end

  // Output byte register. It loads only on a pop, so TxData holds steady
  // through the whole handshake.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)   txdata_q <= 8'h00;
    else if (pop) txdata_q <= mem_q[rd_ptr_q];
  end

  assign TxEn   = txen_q;
  assign TxData = txdata_q;
  assign Full   = full;
  assign Empty  = empty;
  assign Level  = level_q;
  assign Busy   = (state_q != S_IDLE);
  assign Ovf    = ovf_q;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder (ADDR_W=2, TIMEOUT_CYC=64).
// The bench drives the transmitter's TxDone by hand.
// The watchdog steps are compiled only when UART_TXF_TIMEOUT_EN is defined.
module tb_uart_tx_feeder;

  logic       Clk = 1'b0;
  logic       Rst_n;
  logic       WrEn;
  logic [7:0] WrData;
  logic       TxDone;
  logic       TxEn;
  logic [7:0] TxData;
  logic       Full, Empty;
  logic [2:0] Level;
  logic       Busy, Ovf, Err;

  int n_assert = 0;
  int n_fail   = 0;
  int rises_q  = 0;
  logic txen_prev_q = 1'b0;
  int rises_saved;

  uart_tx_feeder #(.ADDR_W(2), .TIMEOUT_CYC(64)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .WrEn(WrEn), .WrData(WrData), .TxDone(TxDone),
    .TxEn(TxEn), .TxData(TxData), .Full(Full), .Empty(Empty), .Level(Level),
    .Busy(Busy), .Ovf(Ovf), .Err(Err)
  );

  always #5 Clk = ~Clk;

  // Count TxEn rising edges seen at the clock.
  always @(posedge Clk) begin
    txen_prev_q <= TxEn;
    if (TxEn && !txen_prev_q) rises_q <= rises_q + 1;
  end

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for TxEn, then check the byte and the 2-cycle pulse.
  task automatic pulse(input string tag, input logic [7:0] b);
    int k = 0;
    while (TxEn !== 1'b1 && k < 40) begin tick; k++; end
    check({tag, "_txen_seen"}, TxEn, 1);
    check({tag, "_data"}, TxData, b);
    tick; check({tag, "_txen_2nd"}, TxEn, 1);
    tick; check({tag, "_txen_off"}, TxEn, 0);
    check({tag, "_busy"}, Busy, 1);
  endtask

  // Transmitter reports done. Ends on the first IDLE cycle after GAP.
  task automatic handshake(input string tag);
    TxDone = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      check({tag, "_hold_txen"}, TxEn, 0);
      check({tag, "_hold_busy"}, Busy, 1);
    end
    TxDone = 1'b0;
    tick; tick;
    check({tag, "_gap_busy"}, Busy, 1);
    tick;
    check({tag, "_idle"}, Busy, 0);
  endtask

  task automatic wr(input logic [7:0] b);
    WrEn = 1'b1; WrData = b;
    tick;
    WrEn = 1'b0;
  endtask

  initial begin
    Rst_n = 1'b0; WrEn = 1'b0; WrData = 8'h00; TxDone = 1'b0;
    tick; tick;
    check("rst_txen", TxEn, 0);   check("rst_data", TxData, 8'h00);
    check("rst_level", Level, 0); check("rst_empty", Empty, 1);
    check("rst_full", Full, 0);   check("rst_busy", Busy, 0);
    check("rst_ovf", Ovf, 0);     check("rst_err", Err, 0);
    Rst_n = 1'b1;
    tick;

    // Single byte A5: the pop and TxEn come one cycle after the write.
    wr(8'hA5);
    check("a5_level", Level, 1); check("a5_txen0", TxEn, 0); check("a5_busy0", Busy, 0);
    tick;
    check("a5_txen", TxEn, 1); check("a5_data", TxData, 8'hA5);
    check("a5_busy", Busy, 1); check("a5_level0", Level, 0);
    tick; check("a5_txen_2nd", TxEn, 1);
    tick; check("a5_txen_off", TxEn, 0);
    tick; tick; check("a5_wait", TxEn, 0); check("a5_data_hold", TxData, 8'hA5);
    handshake("a5");
    check("a5_rises", rises_q, 1);

    // Three back-to-back bytes.
    WrEn = 1'b1; WrData = 8'h11; tick;
    WrData = 8'h22; tick;
    check("b3_lvl_pop", Level, 1); check("b3_txen", TxEn, 1); check("b3_data", TxData, 8'h11);
    WrData = 8'h33; tick;
    WrEn = 1'b0;
    check("b3_lvl2", Level, 2); check("b3_txen2", TxEn, 1);
    tick; check("b3_txen_off", TxEn, 0);
    handshake("b11");
    pulse("b22", 8'h22); handshake("b22");
    pulse("b33", 8'h33); handshake("b33");
    check("b3_rises", rises_q, 4); check("b3_empty", Empty, 1);

    // Stalled transmitter: fill the FIFO and overflow it.
    wr(8'hC0);
    pulse("c0", 8'hC0);
    wr(8'hC1); check("f1_lvl", Level, 1); check("f1_full", Full, 0);
    wr(8'hC2); check("f2_lvl", Level, 2);
    wr(8'hC3); check("f3_lvl", Level, 3); check("f3_full", Full, 0);
    wr(8'hC4); check("f4_lvl", Level, 4); check("f4_full", Full, 1); check("f4_ovf", Ovf, 0);
    wr(8'hC5); check("f5_ovf", Ovf, 1); check("f5_lvl", Level, 4); check("f5_full", Full, 1);
    tick; check("f5_ovf_off", Ovf, 0); check("f5_lvl_hold", Level, 4);
    handshake("c0");
    pulse("c1", 8'hC1); handshake("c1");
    pulse("c2", 8'hC2); handshake("c2");
    pulse("c3", 8'hC3); handshake("c3");
    pulse("c4", 8'hC4); handshake("c4");
    repeat (20) tick;
    check("c5_never", rises_q, 9); check("c_empty", Empty, 1);

    // Same-cycle write and pop at Level 1. Both pointers wrap from 3 to 0.
    wr(8'hD0);
    pulse("d0", 8'hD0);
    wr(8'hD1); check("d1_lvl", Level, 1);
    handshake("d0");
    WrEn = 1'b1; WrData = 8'hD2; tick; WrEn = 1'b0;
    check("d2_lvl_same", Level, 1); check("d1_txen", TxEn, 1); check("d1_data", TxData, 8'hD1);
    tick; tick; check("d1_txen_off", TxEn, 0);
    handshake("d1");
    WrEn = 1'b1; WrData = 8'hD3; tick; WrEn = 1'b0;
    check("d3_lvl_same", Level, 1); check("d2_data", TxData, 8'hD2);
    tick; tick;
    handshake("d2");
    pulse("d3", 8'hD3); handshake("d3");
    check("d_rises", rises_q, 13); check("d_empty", Empty, 1);

    // Reset in the middle of WAIT_DONE with two bytes queued.
    wr(8'hE0);
    pulse("e0", 8'hE0);
    wr(8'hE1); wr(8'hE2);
    check("e_lvl2", Level, 2);
    #2 Rst_n = 1'b0;
    #1;
    check("erst_txen", TxEn, 0); check("erst_level", Level, 0);
    check("erst_empty", Empty, 1); check("erst_busy", Busy, 0);
    check("erst_data", TxData, 8'h00);
    tick; tick;
    Rst_n = 1'b1;
    rises_saved = rises_q;
    repeat (20) tick;
    check("erst_no_txen", rises_q, rises_saved); check("erst_idle", Busy, 0);
    wr(8'hF5);
    pulse("f5", 8'hF5); handshake("f5");

`ifdef UART_TXF_TIMEOUT_EN
    // Watchdog: TxDone stays low, so Err sets after 64 cycles in WAIT_DONE.
    wr(8'h77);
    pulse("t77", 8'h77);
    for (int i = 0; i < 63; i++) begin
      tick; check("to_err_early", Err, 0);
    end
    tick; check("to_err", Err, 1); check("to_gap", Busy, 1);
    tick; check("to_idle", Busy, 0);
    wr(8'h78);
    pulse("t78", 8'h78); handshake("t78");
    check("to_err_sticky", Err, 1);
`else
    check("err_tied0", Err, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
